tx_stream_mux: RTL and testbench
================================

# tx_stream_mux

Parametrised successor to the fixed three-source transmit multiplexer. It merges `SOURCES` framed simple-interface producers (channel buffers, trigger status, future sources) onto one byte stream toward the FT245/UART interface. Arbitration is round-robin, and each frame can be prefixed with an optional source-ID header byte. A stall watchdog aborts frames whose producer stops supplying data. It sits between the channel/trigger blocks and the host link interface, and is clocked by the 100 MHz PLL clock.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of every data word.
- `SOURCES`, 4, number of producer ports (2..16).
- `SRC_ID_WIDTH`, 4, width of the source index; must satisfy 2^SRC_ID_WIDTH ≥ SOURCES.
- `HEADER_EN`, 1, 1 = send header byte `HEADER_BASE | src_index` before each frame.
- `HEADER_BASE`, 8'hA0, constant OR-ed with the source index to form the header.
- `TIMEOUT_CYCLES`, 65535, consecutive stall cycles before a frame is aborted; 0 disables the watchdog.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `src_data` in SOURCES*DATA_WIDTH: packed producer data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_rdy` in SOURCES: producer i holds valid data.
- `src_eof` in SOURCES: asserted together with the last word of a frame.
- `src_ack` out SOURCES: one-cycle pulse; producer i's word has been consumed.
- `tx_data` out DATA_WIDTH: data to the link interface.
- `tx_rdy` out 1: `tx_data` is valid.
- `tx_ack` in 1: one-cycle pulse from the link interface; the word is consumed.
- `busy` out 1: a frame is in progress (HEADER or STREAM state).
- `cur_src` out SRC_ID_WIDTH: index of the granted source.
- `frame_done` out 1: one-cycle pulse after the eof word is acknowledged.
- `frame_abort` out 1: one-cycle pulse when the watchdog aborts a frame.

## Operation
State machine with three states: IDLE, HEADER, STREAM.

IDLE
- Round-robin pointer `ptr` (reset 0). Grant goes to the first i with `src_rdy[i]=1`, searching from `ptr` upward with wrap-around.
- On a grant: latch `cur_src`, assert `busy`, go to HEADER if `HEADER_EN`, otherwise STREAM.
- No request present: stay in IDLE.

HEADER
- `tx_data = HEADER_BASE | cur_src`, `tx_rdy = 1`. No `src_ack` is issued.
- On `tx_ack`: go to STREAM.

STREAM
- Combinational pass-through of the granted source: `tx_data = src_data[cur_src]`, `tx_rdy = src_rdy[cur_src]`, `src_ack[cur_src] = tx_ack & src_rdy[cur_src]`.
- All other `src_ack` bits are 0.
- On an acknowledged word with `src_eof[cur_src]=1`: pulse `frame_done`, set `ptr = cur_src+1` (mod SOURCES), go to IDLE.

Watchdog
- Stall counter is cleared on every acknowledged word and on entry to STREAM.
- It increments each STREAM cycle in which `src_rdy[cur_src]=0`.
- When it reaches `TIMEOUT_CYCLES` (if nonzero): pulse `frame_abort`, set `ptr = cur_src+1`, go to IDLE. No filler word is emitted.
- `tx_ack` arriving while `tx_rdy=0` is ignored in every state.

Boundary conditions
- Grant is not revoked if the granted `src_rdy` drops during HEADER; the header is still sent.
- Simultaneous requests are resolved by round-robin only, so no source waits longer than SOURCES−1 frames.
- `src_eof` without an accompanying ack has no effect.
- A frame of a single word (rdy and eof together) is legal.
- Reset mid-frame: return to IDLE immediately. No `src_ack` or `frame_done` is issued. `ptr` returns to 0.

Reset values: `tx_data` 0, `tx_rdy` 0, `src_ack` 0, `busy` 0, `cur_src` 0, `frame_done` 0, `frame_abort` 0, `ptr` 0, stall counter 0.

## Timing
- Grant latency: `src_rdy` high in IDLE at cycle n → state register updated at n+1; header (or first data word) presented at n+1.
- HEADER → STREAM: the cycle after `tx_ack`.
- STREAM throughput: one word per `tx_ack`, with zero added latency (combinational path from `src_*` and `tx_ack` to `tx_*` and `src_ack`).
- End of frame: `frame_done` is high in the cycle after the eof ack; the state is IDLE in that same cycle. The earliest next header appears one cycle later, giving a one-cycle minimum inter-frame gap.
- Abort: `frame_abort` is high in the cycle after the counter reaches `TIMEOUT_CYCLES`.

## Structure
- Shared package `tx_mux_pkg`: state encoding (IDLE/HEADER/STREAM), default `HEADER_BASE`, and the `SRC_ID_WIDTH` rule.
- Sub-module `rr_arbiter`: inputs `SOURCES` request bits and `ptr`; outputs a one-hot grant, a binary index and an `any` flag. Purely combinational.
- Top FSM, stall counter and output muxing live in `tx_stream_mux`.

## Test plan
- Single source 2 requests a 3-word frame (0x11, 0x22, 0x33 with eof) → tx sequence 0xA2, 0x11, 0x22, 0x33; `src_ack[2]` pulses 3 times; one `frame_done` pulse; `busy` low afterwards.
- Sources 0, 1 and 3 request continuously with 1-word frames → headers in order A0, A1, A3, A0, …; each source is served once per rotation.
- `HEADER_EN=0`, `tx_ack` delayed 5 cycles per word → no header emitted; `tx_data` stable while `tx_rdy=1`; no `src_ack` before `tx_ack`.
- `TIMEOUT_CYCLES=10`, source 1 sends 1 word then drops `rdy` → `frame_abort` pulses at stall cycle 10; next grant goes to source 2 if it is requesting.
- `rst` asserted during STREAM of a 4-word frame after word 2 → all outputs 0 on the next cycle; re-request afterwards is served from `ptr`=0 with a fresh header.

Source files
------------

// File: rtl/tx_mux_pkg.sv
// Shared definitions for the transmit stream multiplexer.
package tx_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

    // Smallest SRC_ID_WIDTH that can index every source.
    function automatic int unsigned min_src_id_width(input int unsigned sources);
        return (sources > 1) ? $clog2(sources) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned SOURCES = 4,
    parameter int unsigned IDX_W   = 4
) (
    input  logic [SOURCES-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [SOURCES-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from ptr upward, taking the first active request.
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < SOURCES; off++) begin
            j = (32'(ptr) + off) % SOURCES;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/tx_stream_mux.sv
// Round-robin merge of framed producers onto one byte stream, with optional
// source-ID header and a stall watchdog.
module tx_stream_mux
    import tx_mux_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           SOURCES        = 4,
    parameter int unsigned           SRC_ID_WIDTH   = 4,
    parameter int unsigned           HEADER_EN      = 1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE    = DATA_WIDTH'(HEADER_BASE_DEFAULT),
    parameter int unsigned           TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SOURCES*DATA_WIDTH-1:0] src_data,
    input  logic [SOURCES-1:0]            src_rdy,
    input  logic [SOURCES-1:0]            src_eof,
    output logic [SOURCES-1:0]            src_ack,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_rdy,
    input  logic                          tx_ack,
    output logic                          busy,
    output logic [SRC_ID_WIDTH-1:0]       cur_src,
    output logic                          frame_done,
    output logic                          frame_abort
);

    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES);

    state_e                  state_q, state_d;
    logic [SRC_ID_WIDTH-1:0] cur_src_q, cur_src_d;
    logic [SOURCES-1:0]      cur_sel_q, cur_sel_d;
    logic [SRC_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic                    frame_done_q, frame_done_d;
    logic                    frame_abort_q, frame_abort_d;

    logic [SOURCES-1:0]      arb_grant;
    logic [SRC_ID_WIDTH-1:0] arb_idx;
    logic                    arb_any;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_rdy;
    logic                    sel_eof;
    logic [SRC_ID_WIDTH-1:0] next_ptr;

    rr_arbiter #(
        .SOURCES (SOURCES),
        .IDX_W   (SRC_ID_WIDTH)
    ) u_arb (
        .req   (src_rdy),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Select the granted producer's word/flags via the latched one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < SOURCES; i++) begin
            if (cur_sel_q[i]) begin
                sel_data = sel_data | src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sel_rdy  = |(src_rdy & cur_sel_q);
        sel_eof  = |(src_eof & cur_sel_q);
        next_ptr = (cur_src_q == SRC_ID_WIDTH'(SOURCES - 1)) ? '0 : cur_src_q + SRC_ID_WIDTH'(1);
    end

    // Next-state, watchdog and stream outputs.
    always_comb begin
        state_d       = state_q;
        cur_src_d     = cur_src_q;
        cur_sel_d     = cur_sel_q;
        ptr_d         = ptr_q;
        stall_d       = stall_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        tx_data       = '0;
        tx_rdy        = 1'b0;
        src_ack       = '0;
        unique case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (arb_any) begin
                    cur_src_d = arb_idx;
                    cur_sel_d = arb_grant;
                    state_d   = (HEADER_EN != 0) ? ST_HEADER : ST_STREAM;
                end
            end
            ST_HEADER: begin
                stall_d = '0;
                tx_data = HEADER_BASE | DATA_WIDTH'(cur_src_q);
                tx_rdy  = 1'b1;
                if (tx_ack) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                tx_data = sel_data;
                tx_rdy  = sel_rdy;
                src_ack = cur_sel_q & {SOURCES{tx_ack & sel_rdy}};
                if (tx_ack && sel_rdy) begin
                    stall_d = '0;
                    if (sel_eof) begin
                        frame_done_d = 1'b1;
                        ptr_d        = next_ptr;
                        state_d      = ST_IDLE;
                    end
                end else if (!sel_rdy) begin
                    stall_d = stall_q + STALL_W'(1);
                    if (TIMEOUT_CYCLES != 0 && stall_d == STALL_LIMIT) begin
                        frame_abort_d = 1'b1;
                        ptr_d         = next_ptr;
                        stall_d       = '0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Block the combinational pass-through while reset is held so that a
        // mid-frame reset never consumes a producer word.
        if (rst) begin
            tx_data = '0;
            tx_rdy  = 1'b0;
            src_ack = '0;
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_src_q     <= '0;
            cur_sel_q     <= '0;
            ptr_q         <= '0;
            stall_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_src_q     <= cur_src_d;
            cur_sel_q     <= cur_sel_d;
            ptr_q         <= ptr_d;
            stall_q       <= stall_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign cur_src     = cur_src_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_tx_stream_mux.sv
// Directed bench for tx_stream_mux: two instances (header+watchdog, and
// headerless without watchdog) share stimulus; the idle one is held in reset.
module tb_tx_stream_mux;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        dsel = 1'b0;
    logic [31:0] src_data = '0;
    logic [3:0]  src_rdy = '0;
    logic [3:0]  src_eof = '0;
    logic        tx_ack = 1'b0;

    logic [7:0] txd_a, txd_b;
    logic       txr_a, txr_b;
    logic [3:0] sack_a, sack_b;
    logic       busy_a, busy_b;
    logic [3:0] cur_a, cur_b;
    logic       fd_a, fd_b, fa_a, fa_b;

    tx_stream_mux #(
        .DATA_WIDTH(8), .SOURCES(4), .SRC_ID_WIDTH(4), .HEADER_EN(1),
        .HEADER_BASE(8'hA0), .TIMEOUT_CYCLES(10)
    ) u_a (
        .clk(clk), .rst(rst_a), .src_data(src_data), .src_rdy(src_rdy),
        .src_eof(src_eof), .src_ack(sack_a), .tx_data(txd_a), .tx_rdy(txr_a),
        .tx_ack(tx_ack), .busy(busy_a), .cur_src(cur_a),
        .frame_done(fd_a), .frame_abort(fa_a)
    );

    tx_stream_mux #(
        .DATA_WIDTH(8), .SOURCES(4), .SRC_ID_WIDTH(4), .HEADER_EN(0),
        .HEADER_BASE(8'hA0), .TIMEOUT_CYCLES(0)
    ) u_b (
        .clk(clk), .rst(rst_b), .src_data(src_data), .src_rdy(src_rdy),
        .src_eof(src_eof), .src_ack(sack_b), .tx_data(txd_b), .tx_rdy(txr_b),
        .tx_ack(tx_ack), .busy(busy_b), .cur_src(cur_b),
        .frame_done(fd_b), .frame_abort(fa_b)
    );

    wire [7:0] tx_data_m = dsel ? txd_b  : txd_a;
    wire       tx_rdy_m  = dsel ? txr_b  : txr_a;
    wire [3:0] src_ack_m = dsel ? sack_b : sack_a;
    wire       busy_m    = dsel ? busy_b : busy_a;
    wire [3:0] cur_src_m = dsel ? cur_b  : cur_a;
    wire       fd_m      = dsel ? fd_b   : fd_a;
    wire       fa_m      = dsel ? fa_b   : fa_a;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Producer queues: bit 8 = eof, bits 7:0 = data. Expected tx byte stream.
    logic [8:0] pq [4][$];
    logic [7:0] exp_q [$];

    int ack_mode = 0;   // 0: tx_ack held high, 1: ack after 5 cycles of tx_rdy
    int wait_cnt = 0;

    // Observation state owned by the compare process.
    int         cyc = 0;
    int         fd_cnt = 0;
    int         fa_cnt = 0;
    int         ack_cnt [4] = '{0, 0, 0, 0};
    int         last_hs_cyc = 0;
    int         abort_gap = -1;
    int         abort_src = -1;
    logic       prev_rdy = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the expected stream and handshake rules.
    always @(negedge clk) begin : compare
        logic       hs;
        logic [3:0] exp_ack;
        logic [7:0] exp_word;
        cyc++;
        hs = tx_rdy_m & tx_ack;
        if (src_ack_m != 4'b0000) begin
            exp_ack = 4'b0001 << cur_src_m;
            chk("src_ack_is_handshake", {27'd0, hs, src_ack_m}, {27'd0, 1'b1, exp_ack});
            chk("tx_passthrough", tx_data_m, src_data[int'(cur_src_m)*8 +: 8]);
        end
        if (hs) begin
            if (exp_q.size() == 0) begin
                chk("tx_word_unexpected", {24'd0, tx_data_m}, 32'h100);
            end else begin
                exp_word = exp_q.pop_front();
                chk("tx_word", tx_data_m, exp_word);
            end
            last_hs_cyc = cyc;
        end
        if (prev_rdy && !prev_hs && tx_rdy_m) begin
            chk("tx_data_stable", tx_data_m, prev_data);
        end
        for (int i = 0; i < 4; i++) begin
            if (src_ack_m[i]) ack_cnt[i]++;
        end
        if (fd_m) begin
            fd_cnt++;
            chk("idle_at_frame_done", busy_m, 0);
        end
        if (fa_m) begin
            fa_cnt++;
            abort_gap = cyc - last_hs_cyc;
            abort_src = int'(cur_src_m);
            chk("idle_at_frame_abort", busy_m, 0);
        end
        prev_rdy  = tx_rdy_m;
        prev_hs   = hs;
        prev_data = tx_data_m;
    end

    task automatic apply_inputs();
        logic [8:0] w;
        for (int i = 0; i < 4; i++) begin
            if (pq[i].size() > 0) begin
                w = pq[i][0];
                src_rdy[i] = 1'b1;
                src_eof[i] = w[8];
                src_data[i*8 +: 8] = w[7:0];
            end else begin
                src_rdy[i] = 1'b0;
                src_eof[i] = 1'b0;
                src_data[i*8 +: 8] = 8'h00;
            end
        end
        if (ack_mode == 0) begin
            tx_ack = 1'b1;
        end else begin
            tx_ack = 1'b0;
            #1;
            if (tx_rdy_m) begin
                wait_cnt++;
                if (wait_cnt >= 5) begin
                    tx_ack = 1'b1;
                    wait_cnt = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    // One clock: record acks before the edge, consume acked words after it.
    task automatic step();
        logic [3:0] acks;
        @(negedge clk);
        acks = src_ack_m;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acks[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        apply_inputs();
    endtask

    task automatic run_until_fd(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (fd_cnt < target && n < budget) begin
            step();
            n++;
        end
        chk(name, (fd_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic run_until_ack(input int src, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (ack_cnt[src] < target && n < budget) begin
            step();
            n++;
        end
        chk(name, (ack_cnt[src] >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic push_words(input int src, input logic [8:0] words [$]);
        foreach (words[k]) pq[src].push_back(words[k]);
    endtask

    initial begin : stim
        int base_fd;
        int base_ack;
        int base_fa;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_tx_rdy", tx_rdy_m, 0);
        chk("rst_tx_data", tx_data_m, 0);
        chk("rst_src_ack", src_ack_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_cur_src", cur_src_m, 0);
        chk("rst_done_abort", {fd_m, fa_m}, 0);
        rst_a = 1'b0;
        step();
        step();
        chk("idle_no_request_busy", busy_m, 0);

        // Round-robin among sources 0, 1, 3 with one-word frames
        push_words(0, '{9'h150, 9'h151});
        push_words(1, '{9'h160, 9'h161});
        push_words(3, '{9'h170, 9'h171});
        exp_q = '{8'hA0, 8'h50, 8'hA1, 8'h60, 8'hA3, 8'h70,
                  8'hA0, 8'h51, 8'hA1, 8'h61, 8'hA3, 8'h71};
        run_until_fd(6, 200, "rr_frames_done");
        chk("rr_acks_src0", ack_cnt[0], 2);
        chk("rr_acks_src1", ack_cnt[1], 2);
        chk("rr_acks_src2", ack_cnt[2], 0);
        chk("rr_acks_src3", ack_cnt[3], 2);
        chk("rr_stream_drained", exp_q.size(), 0);

        // Three-word frame from source 2
        base_fd  = fd_cnt;
        base_ack = ack_cnt[2];
        push_words(2, '{9'h011, 9'h022, 9'h133});
        exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
        run_until_fd(base_fd + 1, 50, "frame3_done");
        step();
        step();
        chk("frame3_acks", ack_cnt[2] - base_ack, 3);
        chk("frame3_done_pulses", fd_cnt - base_fd, 1);
        chk("frame3_busy_after", busy_m, 0);
        chk("frame3_drained", exp_q.size(), 0);

        // Watchdog: source 1 stalls after one word, source 2 waiting
        base_fd = fd_cnt;
        base_fa = fa_cnt;
        push_words(1, '{9'h081});
        push_words(2, '{9'h190});
        exp_q = '{8'hA1, 8'h81, 8'hA2, 8'h90};
        run_until_fd(base_fd + 1, 100, "abort_then_next_done");
        chk("abort_pulses", fa_cnt - base_fa, 1);
        chk("abort_gap_cycles", abort_gap, 11);
        chk("abort_src", abort_src, 1);
        chk("abort_drained", exp_q.size(), 0);

        // Reset in the middle of a four-word frame from source 1
        base_fd  = fd_cnt;
        base_ack = ack_cnt[1];
        push_words(1, '{9'h0C1, 9'h0C2, 9'h0C3, 9'h1C4});
        exp_q = '{8'hA1, 8'hC1, 8'hC2};
        run_until_ack(1, base_ack + 2, 50, "midframe_two_words");
        rst_a = 1'b1;
        push_words(3, '{9'h1D0});
        step();
        rst_a = 1'b0;
        @(negedge clk);
        chk("midrst_tx_rdy", tx_rdy_m, 0);
        chk("midrst_tx_data", tx_data_m, 0);
        chk("midrst_src_ack", src_ack_m, 0);
        chk("midrst_busy", busy_m, 0);
        chk("midrst_cur_src", cur_src_m, 0);
        chk("midrst_no_done", fd_cnt - base_fd, 0);
        chk("midrst_words_taken", ack_cnt[1] - base_ack, 2);
        exp_q = '{8'hA1, 8'hC3, 8'hC4, 8'hA3, 8'hD0};
        run_until_fd(base_fd + 2, 100, "post_reset_frames");
        chk("post_reset_drained", exp_q.size(), 0);

        // Headerless instance, slow link, no watchdog
        rst_a    = 1'b1;
        rst_b    = 1'b0;
        dsel     = 1'b1;
        ack_mode = 1;
        wait_cnt = 0;
        tx_ack   = 1'b0;
        base_fd  = fd_cnt;
        base_fa  = fa_cnt;
        base_ack = ack_cnt[0];
        push_words(0, '{9'h031, 9'h032, 9'h133});
        push_words(2, '{9'h041});
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h41};
        run_until_fd(base_fd + 1, 100, "nohdr_frame_done");
        chk("nohdr_acks_src0", ack_cnt[0] - base_ack, 3);
        base_ack = ack_cnt[2];
        run_until_ack(2, base_ack + 1, 50, "nohdr_src2_word");
        repeat (30) step();
        chk("nowdog_still_busy", busy_m, 1);
        chk("nowdog_cur_src", cur_src_m, 2);
        chk("nowdog_no_abort", fa_cnt - base_fa, 0);
        push_words(2, '{9'h142});
        exp_q.push_back(8'h42);
        run_until_fd(base_fd + 2, 100, "nohdr_second_done");
        chk("nohdr_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
